switch_event_decoder: RTL

SWITCH_EVENT_DECODER -- requirements
Module: switch_event_decoder

---
 rtl/switch_event_pkg.sv | 30 +++
 rtl/switch_event_decoder.sv | 117 +++++++++++
 2 files changed

// File: rtl/switch_event_pkg.sv
// rtl/switch_event_pkg.sv - shared FSM states, event codes and sizing helper for the switch event decoder
package switch_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG_HELD,
    ST_WAIT_SECOND,
    ST_SECOND_PRESSED
  } switch_event_state_t;

  typedef enum logic [1:0] {
    EV_NONE   = 2'b00,
    EV_CLICK  = 2'b01,
    EV_DOUBLE = 2'b10,
    EV_LONG   = 2'b11
  } switch_event_code_t;

  localparam switch_event_code_t CLICK  = EV_CLICK;
  localparam switch_event_code_t DOUBLE = EV_DOUBLE;
  localparam switch_event_code_t LONG   = EV_LONG;

  // One timer serves both the hold and the double-click window, so size it for the larger.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/switch_event_decoder.sv
// rtl/switch_event_decoder.sv - decodes a debounced switch level into CLICK / DOUBLE / LONG events
module switch_event_decoder
  import switch_event_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES   = 1000000,
  parameter int DOUBLE_CLICK_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic       event_valid,
  output logic [1:0] event_code,
  input  logic       event_ack,
  output logic       overrun
);

  localparam int            TW          = timer_width(LONG_PRESS_CYCLES, DOUBLE_CLICK_CYCLES);
  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_PRESS_CYCLES - 1);
  localparam logic [TW-1:0] DOUBLE_LAST = TW'(DOUBLE_CLICK_CYCLES - 1);

  switch_event_state_t state, state_next;
  switch_event_code_t  emit_code, code_q;
  logic [TW-1:0]       timer, timer_next, timer_inc;
  logic                data_in_d, armed, rise, fall, emit;

  // armed masks the first cycle after reset so a switch already held is not seen as a press.
  assign rise      = data_in & ~data_in_d & armed;
  assign fall      = ~data_in & data_in_d;
  assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_in_d <= 1'b0;
      armed     <= 1'b0;
      state     <= ST_IDLE;
      timer     <= '0;
    end else begin
      data_in_d <= data_in;
      armed     <= 1'b1;
      state     <= state_next;
      timer     <= timer_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    emit       = 1'b0;
    emit_code  = EV_NONE;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_next = ST_PRESSED;
          timer_next = '0;
        end
      end
      ST_PRESSED: begin
        if (fall) begin
          state_next = ST_WAIT_SECOND;
          timer_next = '0;
        end else if (timer == LONG_LAST) begin
          state_next = ST_LONG_HELD;
          emit       = 1'b1;
          emit_code  = LONG;
        end else begin
          timer_next = timer_inc;
        end
      end
      ST_LONG_HELD: begin
        if (fall) state_next = ST_IDLE;
      end
      ST_WAIT_SECOND: begin
        if (rise) begin
          state_next = ST_SECOND_PRESSED;
        end else if (timer == DOUBLE_LAST) begin
          state_next = ST_IDLE;
          emit       = 1'b1;
          emit_code  = CLICK;
        end else begin
          timer_next = timer_inc;
        end
      end
      ST_SECOND_PRESSED: begin
        if (fall) begin
          state_next = ST_IDLE;
          emit       = 1'b1;
          emit_code  = DOUBLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A pending event is replaced only when it is acknowledged in the same cycle; otherwise the newcomer is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_valid <= 1'b0;
      code_q      <= EV_NONE;
      overrun     <= 1'b0;
    end else begin
      if (emit && (!event_valid || event_ack)) begin
        event_valid <= 1'b1;
        code_q      <= emit_code;
      end else if (event_valid && event_ack) begin
        event_valid <= 1'b0;
      end
      if (emit && event_valid && !event_ack) begin
        overrun <= 1'b1;
      end else if (event_valid && event_ack) begin
        overrun <= 1'b0;
      end
    end
  end

  assign event_code = code_q;

endmodule
